parking_gate_ctrl: RTL and testbench

- Consumes the debounced vehicle-presence levels from the entry and exit IR sensor stages, one per lane.
- Runs a single-gate-at-a-time FSM that opens the entry or exit barrier, waits for the car to clear, then closes the barrier and updates the occupancy count.
- Drives barrier outputs, occupancy count, full/empty status, and a reject pulse for the display/LED stage.

---
 rtl/parking_gate_ctrl.sv | 147 ++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// rtl/parking_gate_ctrl.sv - single-barrier-at-a-time parking gate FSM with occupancy count
module parking_gate_ctrl #(
    parameter int CAPACITY = 16,
    parameter int CNT_W    = 8,
    parameter int HOLD_MS  = 500,
    parameter int TMR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_ms,
    input  logic             entry_det,
    input  logic             exit_det,
    output logic             gate_in_open,
    output logic             gate_out_open,
    output logic [CNT_W-1:0] car_count,
    output logic             full,
    output logic             empty,
    output logic             full_reject
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IN_OPEN  = 3'd1,
        IN_HOLD  = 3'd2,
        OUT_OPEN = 3'd3,
        OUT_HOLD = 3'd4
    } state_t;

    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_MS - 1);
    localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             gate_in_q, gate_in_d;
    logic             gate_out_q, gate_out_d;
    logic             reject_q, reject_d;
    logic             entry_prev_q, entry_prev_d;
    logic             inc, dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            gate_in_q    <= 1'b0;
            gate_out_q   <= 1'b0;
            reject_q     <= 1'b0;
            entry_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            gate_in_q    <= gate_in_d;
            gate_out_q   <= gate_out_d;
            reject_q     <= reject_d;
            entry_prev_q <= entry_prev_d;
        end
    end

    // Exit is checked first so a departing car frees a slot before an entry is considered.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        inc     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (exit_det && !empty_q) begin
                    state_d = OUT_OPEN;
                end else if (entry_det && !full_q) begin
                    state_d = IN_OPEN;
                end
            end
            IN_OPEN: begin
                if (!entry_det) begin
                    state_d = IN_HOLD;
                    timer_d = '0;
                end
            end
            IN_HOLD: begin
                if (entry_det) begin
                    state_d = IN_OPEN;
                end else if (tick_ms) begin
                    if (timer_q == HOLD_LAST) begin
                        state_d = IDLE;
                        inc     = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            OUT_OPEN: begin
                if (!exit_det) begin
                    state_d = OUT_HOLD;
                    timer_d = '0;
                end
            end
            OUT_HOLD: begin
                if (exit_det) begin
                    state_d = OUT_OPEN;
                end else if (tick_ms) begin
                    if (timer_q == HOLD_LAST) begin
                        state_d = IDLE;
                        dec     = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so barriers and count move on the transition edge.
    always_comb begin
        gate_in_d    = (state_d == IN_OPEN) || (state_d == IN_HOLD);
        gate_out_d   = (state_d == OUT_OPEN) || (state_d == OUT_HOLD);
        count_d      = count_q;
        if (inc) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d       = (count_d == CAP);
        empty_d      = (count_d == '0);
        entry_prev_d = entry_det;
        reject_d     = entry_det && !entry_prev_q && full_q;
    end

    assign gate_in_open  = gate_in_q;
    assign gate_out_open = gate_out_q;
    assign car_count     = count_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign full_reject   = reject_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb/tb_parking_gate_ctrl.sv - vector table and scoreboard bench for parking_gate_ctrl
module tb_parking_gate_ctrl;

    localparam int CAPACITY = 2;
    localparam int CNT_W    = 8;
    localparam int HOLD_MS  = 3;
    localparam int TMR_W    = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tick_ms;
    logic             entry_det;
    logic             exit_det;
    logic             gate_in_open;
    logic             gate_out_open;
    logic [CNT_W-1:0] car_count;
    logic             full;
    logic             empty;
    logic             full_reject;

    int n_checks = 0;
    int n_fail   = 0;

    parking_gate_ctrl #(
        .CAPACITY(CAPACITY),
        .CNT_W   (CNT_W),
        .HOLD_MS (HOLD_MS),
        .TMR_W   (TMR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_ms      (tick_ms),
        .entry_det    (entry_det),
        .exit_det     (exit_det),
        .gate_in_open (gate_in_open),
        .gate_out_open(gate_out_open),
        .car_count    (car_count),
        .full         (full),
        .empty        (empty),
        .full_reject  (full_reject)
    );

    always #5 clk = ~clk;

    // nt tick periods (9 quiet clocks + 1 tick clock), then nc quiet clocks, then one tick clock if tk.
    typedef struct {
        logic en;
        logic ex;
        int   nt;
        int   nc;
        logic tk;
        logic gi;
        logic go;
        int   cnt;
        logic fu;
        logic em;
        logic rj;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic add(input logic en, input logic ex, input int nt, input int nc, input logic tk,
                       input logic gi, input logic go, input int cnt, input logic fu,
                       input logic em, input logic rj);
        vec_t v;
        v.en = en; v.ex = ex; v.nt = nt; v.nc = nc; v.tk = tk;
        v.gi = gi; v.go = go; v.cnt = cnt; v.fu = fu; v.em = em; v.rj = rj;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_clocks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_clock();
        tick_ms = 1'b1;
        run_clocks(1);
        tick_ms = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        chk({tag, " gate_in_open"},  int'(gate_in_open),  int'(e.gi));
        chk({tag, " gate_out_open"}, int'(gate_out_open), int'(e.go));
        chk({tag, " car_count"},     int'(car_count),     e.cnt);
        chk({tag, " full"},          int'(full),          int'(e.fu));
        chk({tag, " empty"},         int'(empty),         int'(e.em));
        chk({tag, " full_reject"},   int'(full_reject),   int'(e.rj));
    endtask

    initial begin
        vec_t cur;
        vec_t e;
        rst_n     = 1'b0;
        tick_ms   = 1'b0;
        entry_det = 1'b0;
        exit_det  = 1'b0;

        //   en ex nt nc tk | gi go cnt fu em rj
        add(0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0);   // idle after reset
        add(1, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0);   // entry opens one clock after det
        add(1, 0, 2, 0, 0,  1, 0, 0, 0, 1, 0);   // ticks while open are ignored
        add(0, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0);
        add(0, 0, 2, 9, 0,  1, 0, 0, 0, 1, 0);   // still open just before 3rd tick
        add(0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);   // closes on 3rd tick
        add(1, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0);   // re-blocked during hold
        add(0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0);
        add(0, 0, 2, 0, 0,  1, 0, 1, 0, 0, 0);   // original close time has passed
        add(0, 0, 0, 9, 1,  0, 0, 2, 1, 0, 0);   // close 3 ticks after second fall
        add(1, 0, 0, 1, 0,  0, 0, 2, 1, 0, 1);   // arrival while full
        add(1, 0, 0, 1, 0,  0, 0, 2, 1, 0, 0);
        add(1, 0, 1, 5, 0,  0, 0, 2, 1, 0, 0);
        add(1, 1, 0, 1, 0,  0, 1, 2, 1, 0, 0);   // exit served while entry waits
        add(1, 0, 0, 1, 0,  0, 1, 2, 1, 0, 0);
        add(1, 0, 2, 9, 0,  0, 1, 2, 1, 0, 0);
        add(1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0);   // waiting car admitted
        add(0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0);
        add(0, 0, 3, 0, 0,  0, 0, 2, 1, 0, 0);
        add(0, 1, 0, 1, 0,  0, 1, 2, 1, 0, 0);
        add(0, 0, 0, 1, 0,  0, 1, 2, 1, 0, 0);
        add(0, 0, 3, 0, 0,  0, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0,  0, 1, 1, 0, 0, 0);   // simultaneous: exit first
        add(1, 0, 0, 1, 0,  0, 1, 1, 0, 0, 0);
        add(1, 0, 3, 0, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0);
        add(0, 0, 3, 0, 0,  0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0,  1, 0, 1, 0, 0, 0);   // mid-hold, timer = 1

        run_clocks(3);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cur       = vecs[i];
            entry_det = cur.en;
            exit_det  = cur.ex;
            exp_q.push_back(cur);
            for (int t = 0; t < cur.nt; t++) begin
                run_clocks(9);
                tick_clock();
            end
            run_clocks(cur.nc);
            if (cur.tk) tick_clock();
            e = exp_q.pop_front();
            check_outputs($sformatf("vec%0d", i), e);
        end

        // Asynchronous reset in the middle of an entry hold.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst gate_in_open",  int'(gate_in_open),  0);
        chk("rst gate_out_open", int'(gate_out_open), 0);
        chk("rst car_count",     int'(car_count),     0);
        chk("rst empty",         int'(empty),         1);
        chk("rst full",          int'(full),          0);
        run_clocks(2);
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            run_clocks(9);
            tick_clock();
        end
        chk("post-rst gate_in_open", int'(gate_in_open), 0);
        chk("post-rst car_count",    int'(car_count),    0);
        chk("post-rst empty",        int'(empty),        1);

        // Exit request at empty must be ignored.
        exit_det = 1'b1;
        run_clocks(3);
        chk("empty-exit gate_out_open", int'(gate_out_open), 0);
        chk("empty-exit car_count",     int'(car_count),     0);
        exit_det = 1'b0;
        run_clocks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
